// File: rtl/dual_adc_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dual_adc_stream_arbiter
// Brief   : Buffers the left/right ADC strobe streams in per-channel FIFOs and
//           merges them round-robin onto one channel-tagged valid/ready stream.
//           Optional drop counters: define DUAL_ADC_ARB_DROPCNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module dual_adc_stream_arbiter #(
  parameter int DATA_WIDTH = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] ldata,
  input  logic                  lstrb,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rstrb,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_chan,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  ovf_l,
  output logic                  ovf_r,
  input  logic                  ovf_clear
`ifdef DUAL_ADC_ARB_DROPCNT_EN
  ,
  output logic [7:0]            drop_cnt_l,
  output logic [7:0]            drop_cnt_r
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_MSB = {1'b1, {AW{1'b0}}};

  logic [DATA_WIDTH-1:0] mem_l_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_l_d [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_r_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_r_d [FIFO_DEPTH];
  logic [PW-1:0]         wptr_l_q, wptr_l_d, rptr_l_q, rptr_l_d;
  logic [PW-1:0]         wptr_r_q, wptr_r_d, rptr_r_q, rptr_r_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_chan_q, out_chan_d;
  logic                  out_valid_q, out_valid_d;
  logic                  last_q, last_d;
  logic                  ovf_l_q, ovf_l_d, ovf_r_q, ovf_r_d;

  logic empty_l, empty_r, full_l, full_r;
  logic push_l, push_r, drop_l, drop_r;
  logic slot_free, pop_l, pop_r;

  // Full/empty come from start-of-cycle pointers, so a pop in the same cycle
  // never rescues a strobe that arrives on a full FIFO.
  always_comb begin
    empty_l   = (wptr_l_q == rptr_l_q);
    empty_r   = (wptr_r_q == rptr_r_q);
    full_l    = ((wptr_l_q ^ rptr_l_q) == PTR_MSB);
    full_r    = ((wptr_r_q ^ rptr_r_q) == PTR_MSB);
    push_l    = lstrb & ~full_l;
    push_r    = rstrb & ~full_r;
    drop_l    = lstrb & full_l;
    drop_r    = rstrb & full_r;
    slot_free = ~out_valid_q | out_ready;
    pop_l     = 1'b0;
    pop_r     = 1'b0;
    if (slot_free) begin
      if (!empty_l && !empty_r) begin
        pop_l = last_q;
        pop_r = ~last_q;
      end else begin
        pop_l = ~empty_l;
        pop_r = empty_l & ~empty_r;
      end
    end
  end

  always_comb begin
    mem_l_d  = mem_l_q;
    mem_r_d  = mem_r_q;
    wptr_l_d = wptr_l_q;
    wptr_r_d = wptr_r_q;
    rptr_l_d = rptr_l_q;
    rptr_r_d = rptr_r_q;
    if (push_l) begin
      mem_l_d[wptr_l_q[AW-1:0]] = ldata;
      wptr_l_d = wptr_l_q + PW'(1);
    end
    if (push_r) begin
      mem_r_d[wptr_r_q[AW-1:0]] = rdata;
      wptr_r_d = wptr_r_q + PW'(1);
    end
    if (pop_l) rptr_l_d = rptr_l_q + PW'(1);
    if (pop_r) rptr_r_d = rptr_r_q + PW'(1);
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    if (pop_l) begin
      out_data_d  = mem_l_q[rptr_l_q[AW-1:0]];
      out_chan_d  = 1'b0;
      out_valid_d = 1'b1;
      last_d      = 1'b0;
    end else if (pop_r) begin
      out_data_d  = mem_r_q[rptr_r_q[AW-1:0]];
      out_chan_d  = 1'b1;
      out_valid_d = 1'b1;
      last_d      = 1'b1;
    end else if (slot_free) begin
      out_valid_d = 1'b0;
    end
    ovf_l_d = drop_l | (ovf_l_q & ~ovf_clear);
    ovf_r_d = drop_r | (ovf_r_q & ~ovf_clear);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_l_q     <= '{default: '0};
      mem_r_q     <= '{default: '0};
      wptr_l_q    <= '0;
      rptr_l_q    <= '0;
      wptr_r_q    <= '0;
      rptr_r_q    <= '0;
      out_data_q  <= '0;
      out_chan_q  <= 1'b0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b1;
      ovf_l_q     <= 1'b0;
      ovf_r_q     <= 1'b0;
    end else begin
      mem_l_q     <= mem_l_d;
      mem_r_q     <= mem_r_d;
      wptr_l_q    <= wptr_l_d;
      rptr_l_q    <= rptr_l_d;
      wptr_r_q    <= wptr_r_d;
      rptr_r_q    <= rptr_r_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
      ovf_l_q     <= ovf_l_d;
      ovf_r_q     <= ovf_r_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;
  assign ovf_l     = ovf_l_q;
  assign ovf_r     = ovf_r_q;

`ifdef DUAL_ADC_ARB_DROPCNT_EN
  logic [7:0] drop_cnt_l_q, drop_cnt_l_d, drop_cnt_r_q, drop_cnt_r_d;

  // A clear restarts counting, so a drop in the clearing cycle leaves 1.
  always_comb begin
    drop_cnt_l_d = drop_cnt_l_q;
    drop_cnt_r_d = drop_cnt_r_q;
    if (ovf_clear) begin
      drop_cnt_l_d = {7'd0, drop_l};
      drop_cnt_r_d = {7'd0, drop_r};
    end else begin
      if (drop_l && drop_cnt_l_q != 8'hFF) drop_cnt_l_d = drop_cnt_l_q + 8'd1;
      if (drop_r && drop_cnt_r_q != 8'hFF) drop_cnt_r_d = drop_cnt_r_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_cnt_l_q <= 8'd0;
      drop_cnt_r_q <= 8'd0;
    end else begin
      drop_cnt_l_q <= drop_cnt_l_d;
      drop_cnt_r_q <= drop_cnt_r_d;
    end
  end

  assign drop_cnt_l = drop_cnt_l_q;
  assign drop_cnt_r = drop_cnt_r_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dual_adc_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dual_adc_stream_arbiter
// Brief   : Directed stimulus with per-channel expected-word queues drained by
//           an independent output monitor.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dual_adc_stream_arbiter;

  localparam int DW = 12;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] ldata = '0;
  logic          lstrb = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic          rstrb = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_chan;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          ovf_l;
  logic          ovf_r;
  logic          ovf_clear = 1'b0;
`ifdef DUAL_ADC_ARB_DROPCNT_EN
  logic [7:0]    drop_cnt_l;
  logic [7:0]    drop_cnt_r;
`endif

  dual_adc_stream_arbiter #(.DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .ldata     (ldata),
    .lstrb     (lstrb),
    .rdata     (rdata),
    .rstrb     (rstrb),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf_l     (ovf_l),
    .ovf_r     (ovf_r),
    .ovf_clear (ovf_clear)
`ifdef DUAL_ADC_ARB_DROPCNT_EN
    ,
    .drop_cnt_l(drop_cnt_l),
    .drop_cnt_r(drop_cnt_r)
`endif
  );

  always #5 clock = ~clock;

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_l[$];
  logic [DW-1:0] exp_r[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    lstrb = 1'b0;
    rstrb = 1'b0;
    ovf_clear = 1'b0;
    exp_l.delete();
    exp_r.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (exp_l.size() != 0 || exp_r.size() != 0); i++) tick();
    check("drain_left_left_over", exp_l.size(), 0);
    check("drain_right_left_over", exp_r.size(), 0);
  endtask

  // Monitor: scores every accepted word and checks that a stalled word holds.
  logic          hold_prev = 1'b0;
  logic          rst_prev = 1'b1;
  logic [DW-1:0] data_prev = '0;
  logic          chan_prev = 1'b0;

  always @(negedge clock) begin
    if (!reset && !rst_prev && hold_prev) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_data", {20'd0, out_data}, {20'd0, data_prev});
      check("hold_chan", {31'd0, out_chan}, {31'd0, chan_prev});
    end
    if (!reset && out_valid && out_ready) begin
      if (!out_chan) begin
        if (exp_l.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_left_word: got 0x%0h, expected none", out_data);
        end else begin
          check("left_word", {20'd0, out_data}, {20'd0, exp_l.pop_front()});
        end
      end else begin
        if (exp_r.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_right_word: got 0x%0h, expected none", out_data);
        end else begin
          check("right_word", {20'd0, out_data}, {20'd0, exp_r.pop_front()});
        end
      end
    end
    hold_prev = !reset && out_valid && !out_ready;
    data_prev = out_data;
    chan_prev = out_chan;
    rst_prev  = reset;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_data", {20'd0, out_data}, 32'd0);
    check("reset_out_chan", {31'd0, out_chan}, 32'd0);
    check("reset_ovf_l", {31'd0, ovf_l}, 32'd0);
    check("reset_ovf_r", {31'd0, ovf_r}, 32'd0);
`ifdef DUAL_ADC_ARB_DROPCNT_EN
    check("reset_drop_cnt_l", {24'd0, drop_cnt_l}, 32'd0);
    check("reset_drop_cnt_r", {24'd0, drop_cnt_r}, 32'd0);
`endif

    // Single-sample latency: strobe in N, valid in N+2 only.
    out_ready = 1'b1;
    ldata = 12'h123;
    lstrb = 1'b1;
    exp_l.push_back(12'h123);
    tick();
    lstrb = 1'b0;
    check("lat_n1_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("lat_n2_valid", {31'd0, out_valid}, 32'd1);
    check("lat_n2_data", {20'd0, out_data}, 32'h123);
    check("lat_n2_chan", {31'd0, out_chan}, 32'd0);
    tick();
    check("lat_n3_valid", {31'd0, out_valid}, 32'd0);

    // Simultaneous strobes, twice: strict left/right alternation.
    do_reset();
    out_ready = 1'b1;
    ldata = 12'hAAA;
    rdata = 12'h555;
    lstrb = 1'b1;
    rstrb = 1'b1;
    exp_l.push_back(12'hAAA);
    exp_r.push_back(12'h555);
    tick();
    ldata = 12'hAAB;
    rdata = 12'h556;
    exp_l.push_back(12'hAAB);
    exp_r.push_back(12'h556);
    tick();
    lstrb = 1'b0;
    rstrb = 1'b0;
    check("rr0_data", {20'd0, out_data}, 32'hAAA);
    check("rr0_chan", {31'd0, out_chan}, 32'd0);
    tick();
    check("rr1_data", {20'd0, out_data}, 32'h555);
    check("rr1_chan", {31'd0, out_chan}, 32'd1);
    tick();
    check("rr2_data", {20'd0, out_data}, 32'hAAB);
    check("rr2_chan", {31'd0, out_chan}, 32'd0);
    tick();
    check("rr3_data", {20'd0, out_data}, 32'h556);
    check("rr3_chan", {31'd0, out_chan}, 32'd1);
    check("rr3_valid", {31'd0, out_valid}, 32'd1);
    drain();

    // Overflow: slot + 4 FIFO entries hold 5 words, the 6th is dropped.
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      ldata = DW'(i);
      lstrb = 1'b1;
      if (i <= 5) exp_l.push_back(DW'(i));
      tick();
    end
    lstrb = 1'b0;
    check("ovf_l_set", {31'd0, ovf_l}, 32'd1);
    check("ovf_r_quiet", {31'd0, ovf_r}, 32'd0);
    check("ovf_slot_data", {20'd0, out_data}, 32'h001);
`ifdef DUAL_ADC_ARB_DROPCNT_EN
    check("drop_cnt_l_one", {24'd0, drop_cnt_l}, 32'd1);
    check("drop_cnt_r_zero", {24'd0, drop_cnt_r}, 32'd0);
`endif
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    check("ovf_l_cleared", {31'd0, ovf_l}, 32'd0);
`ifdef DUAL_ADC_ARB_DROPCNT_EN
    check("drop_cnt_l_cleared", {24'd0, drop_cnt_l}, 32'd0);
`endif
    ldata = 12'h007;
    lstrb = 1'b1;
    ovf_clear = 1'b1;
    tick();
    lstrb = 1'b0;
    ovf_clear = 1'b0;
    check("ovf_l_set_wins", {31'd0, ovf_l}, 32'd1);
`ifdef DUAL_ADC_ARB_DROPCNT_EN
    check("drop_cnt_l_clear_and_drop", {24'd0, drop_cnt_l}, 32'd1);
`endif
    out_ready = 1'b1;
    drain();

    // Toggling out_ready with interleaved traffic on both channels.
    do_reset();
    fork
      begin
        for (int c = 0; c < 60; c++) begin
          out_ready = c[0];
          tick();
        end
      end
      begin
        for (int i = 0; i < 8; i++) begin
          ldata = DW'(12'h100 + i);
          lstrb = 1'b1;
          exp_l.push_back(DW'(12'h100 + i));
          tick();
          lstrb = 1'b0;
          tick();
          tick();
          rdata = DW'(12'h200 + i);
          rstrb = 1'b1;
          exp_r.push_back(DW'(12'h200 + i));
          tick();
          rstrb = 1'b0;
          tick();
          tick();
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check("toggle_ovf_l", {31'd0, ovf_l}, 32'd0);
    check("toggle_ovf_r", {31'd0, ovf_r}, 32'd0);

    // Reset with buffered words: nothing stale may emerge afterwards.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ldata = DW'(12'h3A1 + i);
      lstrb = 1'b1;
      tick();
    end
    lstrb = 1'b0;
    tick();
    check("prerst_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b1;
    tick();
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("postrst_valid", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
